// File: rtl/snr_estimator_if.sv
// Handshake bundle for snr_estimator: sample stream in, SNR code out.
// SNR_EST_POWER_OUT_EN adds the averaged power outputs.
interface snr_estimator_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              sample_valid;
  logic [DATA_W-1:0] Y;
  logic [DATA_W-1:0] Y_hat;
  logic              busy;
  logic              result_valid;
  logic [2:0]        select_est;
`ifdef SNR_EST_POWER_OUT_EN
  logic [31:0]       sig_pow;
  logic [31:0]       noise_pow;
`endif

  modport master (
    output start, sample_valid, Y, Y_hat,
`ifdef SNR_EST_POWER_OUT_EN
    input  sig_pow, noise_pow,
`endif
    input  busy, result_valid, select_est
  );

  modport slave (
    input  start, sample_valid, Y, Y_hat,
`ifdef SNR_EST_POWER_OUT_EN
    output sig_pow, noise_pow,
`endif
    output busy, result_valid, select_est
  );
endinterface

// File: rtl/snr_estimator.sv
// Windowed signal/error power accumulator that buckets SNR into a 3-bit code.
// Optional macro SNR_EST_POWER_OUT_EN exposes averaged powers.
module snr_estimator #(
  parameter int DATA_W   = 32,
  parameter int LOG2_WIN = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  snr_estimator_if.slave io
);
  localparam int PROD_W = 2*DATA_W + 2;
  localparam int ACC_W  = PROD_W + LOG2_WIN;
  localparam int CMP_W  = ACC_W + 12;
  localparam logic [LOG2_WIN:0] LAST =
    (LOG2_WIN+1)'(2**LOG2_WIN - 1);

  typedef enum logic [1:0] {
    IDLE, ACCUM, COMPARE, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   ps_q, ps_d;
  logic [ACC_W-1:0]   pn_q, pn_d;
  logic [LOG2_WIN:0]  cnt_q, cnt_d;
  logic [2:0]         k_q, k_d;
  logic               found_q, found_d;
  logic [2:0]         code_q, code_d;
  logic [2:0]         sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               rv_q, rv_d;

  logic signed [DATA_W:0]     e;
  logic signed [2*DATA_W-1:0] ysq;
  logic signed [PROD_W-1:0]   esq;
  logic [PROD_W-1:0]          y_pow, e_pow;
  logic [CMP_W-1:0]           ps_x, pn_x, lhs, rhs;
  logic [2:0]                 lvl;

  always_comb begin
    e = $signed({io.Y_hat[DATA_W-1], io.Y_hat})
      - $signed({io.Y[DATA_W-1], io.Y});
    ysq   = $signed(io.Y) * $signed(io.Y);
    esq   = e * e;
    y_pow = {2'b00, ysq};
    e_pow = $unsigned(esq);
  end

  // Constant multiples are evaluated 12 bits wider so 3162*P_n never wraps.
  always_comb begin
    ps_x = CMP_W'(ps_q);
    pn_x = CMP_W'(pn_q);
    lhs  = '0;
    rhs  = '1;
    lvl  = 3'b111;
    case (k_q)
      3'd0: begin
        lhs = ps_x; rhs = pn_x * CMP_W'(3162); lvl = 3'b000;
      end
      3'd1: begin
        lhs = ps_x; rhs = pn_x * CMP_W'(316);  lvl = 3'b001;
      end
      3'd2: begin
        lhs = ps_x; rhs = pn_x * CMP_W'(32);   lvl = 3'b010;
      end
      3'd3: begin
        lhs = ps_x; rhs = pn_x * CMP_W'(3);    lvl = 3'b100;
      end
      3'd4: begin
        lhs = ps_x << 4; rhs = pn_x * CMP_W'(5); lvl = 3'b011;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    pn_d    = pn_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    found_d = found_q;
    code_d  = code_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = ACCUM;
          ps_d    = '0;
          pn_d    = '0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (io.sample_valid) begin
          ps_d  = ps_q + ACC_W'(y_pow);
          pn_d  = pn_q + ACC_W'(e_pow);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = COMPARE;
            k_d     = '0;
            found_d = 1'b0;
            code_d  = 3'b111;
          end
        end
      end
      COMPARE: begin
        if (k_q == 3'd5) begin
          state_d = DONE;
          sel_d   = found_q ? code_q : 3'b111;
        end else begin
          k_d = k_q + 1'b1;
          if (!found_q && lhs >= rhs) begin
            found_d = 1'b1;
            code_d  = lvl;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    rv_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ps_q    <= '0;
      pn_q    <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      found_q <= 1'b0;
      code_q  <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      pn_q    <= pn_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      found_q <= found_d;
      code_q  <= code_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
    end
  end

  assign io.busy         = busy_q;
  assign io.result_valid = rv_q;
  assign io.select_est   = sel_q;

`ifdef SNR_EST_POWER_OUT_EN
  logic [31:0] sp_q, sp_d, np_q, np_d;

  function automatic logic [31:0] sat32(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] s;
    s = v >> LOG2_WIN;
    return (|s[ACC_W-1:32]) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    sp_d = sp_q;
    np_d = np_q;
    if (state_q == COMPARE && state_d == DONE) begin
      sp_d = sat32(ps_q);
      np_d = sat32(pn_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp_q <= '0;
      np_q <= '0;
    end else begin
      sp_q <= sp_d;
      np_q <= np_d;
    end
  end

  assign io.sig_pow   = sp_q;
  assign io.noise_pow = np_q;
`endif
endmodule

// File: tb/tb_snr_estimator.sv
// Directed and random measurements of snr_estimator against a
// wide-integer power/threshold reference model.
module tb_snr_estimator;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  snr_estimator_if #(.DATA_W(32)) io();

  snr_estimator #(.DATA_W(32), .LOG2_WIN(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io(io)
  );

  int total = 0;
  int bad = 0;
  int ys[16];
  int yh[16];
  logic [127:0] m_ps, m_pn;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact powers with plain wide arithmetic, then the threshold ladder.
  function automatic logic [2:0] model();
    logic signed [127:0] a, b, d;
    m_ps = '0;
    m_pn = '0;
    for (int i = 0; i < 16; i++) begin
      a = ys[i];
      b = yh[i];
      d = b - a;
      m_ps = m_ps + 128'(a * a);
      m_pn = m_pn + 128'(d * d);
    end
    if (m_ps >= 3162 * m_pn)         return 3'b000;
    else if (m_ps >= 316 * m_pn)     return 3'b001;
    else if (m_ps >= 32 * m_pn)      return 3'b010;
    else if (m_ps >= 3 * m_pn)       return 3'b100;
    else if (16 * m_ps >= 5 * m_pn)  return 3'b011;
    else                             return 3'b111;
  endfunction

  function automatic logic [31:0] avg32(input logic [127:0] v);
    logic [127:0] s;
    s = v >> 4;
    return (|s[127:32]) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic fill_alt(input int y, input int e);
    for (int i = 0; i < 16; i++) begin
      ys[i] = y;
      yh[i] = (i % 2 == 0) ? y + e : y - e;
    end
  endtask

  task automatic fill_rand(input int sh_y, input int sh_e);
    for (int i = 0; i < 16; i++) begin
      ys[i] = int'($urandom) >>> sh_y;
      yh[i] = ys[i] + (int'($urandom) >>> sh_e);
    end
  endtask

  task automatic measure(input string tag, input bit gap,
                         input bit poke, input logic [2:0] exp);
    int j;
    logic [2:0] mc;
    mc = model();
    @(negedge clk);
    io.start = 1'b1;
    io.sample_valid = 1'b1;
    io.Y = ys[0];
    io.Y_hat = ys[0] + 50000;
    @(negedge clk);
    io.start = 1'b0;
    io.sample_valid = 1'b0;
    chk({tag, "_busy_start"}, 32'(io.busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      io.sample_valid = 1'b1;
      io.Y = ys[i];
      io.Y_hat = yh[i];
      if (poke && i == 5) io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      if (gap) begin
        io.sample_valid = 1'b0;
        io.Y_hat = 32'h7fff_0000;
        @(negedge clk);
      end
    end
    io.sample_valid = 1'b0;
    j = gap ? 2 : 1;
    while (!io.result_valid && j < 14) begin
      if (poke && j == 3) io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      j++;
    end
    chk({tag, "_latency"}, 32'(j), 32'd7);
    chk({tag, "_rv"}, 32'(io.result_valid), 32'd1);
    chk({tag, "_busy_done"}, 32'(io.busy), 32'd1);
    chk({tag, "_code"}, 32'(io.select_est), 32'(exp));
    chk({tag, "_code_model"}, 32'(io.select_est), 32'(mc));
`ifdef SNR_EST_POWER_OUT_EN
    chk({tag, "_sig_pow"}, io.sig_pow, avg32(m_ps));
    chk({tag, "_noise_pow"}, io.noise_pow, avg32(m_pn));
`endif
    @(negedge clk);
    chk({tag, "_rv_pulse"}, 32'(io.result_valid), 32'd0);
    chk({tag, "_busy_end"}, 32'(io.busy), 32'd0);
    chk({tag, "_hold"}, 32'(io.select_est), 32'(exp));
  endtask

  initial begin
    int rv_cnt;
    logic [2:0] rc;
    io.start = 1'b0;
    io.sample_valid = 1'b0;
    io.Y = '0;
    io.Y_hat = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_rv", 32'(io.result_valid), 32'd0);
    chk("rst_sel", 32'(io.select_est), 32'd0);

    // Samples offered while idle must not count.
    io.sample_valid = 1'b1;
    io.Y = 32'd5;
    io.Y_hat = 32'd900;
    repeat (3) @(negedge clk);
    io.sample_valid = 1'b0;
    chk("idle_busy", 32'(io.busy), 32'd0);

    fill_alt(1000, 0);    measure("clean", 1'b0, 1'b0, 3'b000);
    fill_alt(1000, 30);   measure("e30", 1'b0, 1'b0, 3'b001);
    fill_alt(1000, 1000); measure("e1000", 1'b0, 1'b0, 3'b011);
    fill_alt(1000, 2000); measure("e2000", 1'b0, 1'b0, 3'b111);
    fill_alt(1000, 10);   measure("gap", 1'b1, 1'b0, 3'b000);
    fill_alt(1000, 0);    measure("poke", 1'b0, 1'b1, 3'b000);
    fill_alt(0, 5);       measure("zero_sig", 1'b0, 1'b0, 3'b111);
    fill_alt(1000, 100);  measure("e100", 1'b0, 1'b0, 3'b010);

    // Abort after 8 samples.
    @(negedge clk);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      io.sample_valid = 1'b1;
      io.Y = 32'd1000;
      io.Y_hat = 32'd3000;
      @(negedge clk);
    end
    io.sample_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_busy", 32'(io.busy), 32'd0);
    chk("abort_rv", 32'(io.result_valid), 32'd0);
    chk("abort_sel", 32'(io.select_est), 32'd0);
    rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (io.result_valid) rv_cnt++;
    end
    chk("abort_no_result", 32'(rv_cnt), 32'd0);
    fill_alt(1000, 100);  measure("after_abort", 1'b0, 1'b0, 3'b010);

    // Extreme full-scale error.
    for (int i = 0; i < 16; i++) begin
      ys[i] = 32'h8000_0000;
      yh[i] = 32'h7fff_ffff;
    end
    measure("extreme", 1'b0, 1'b0, 3'b111);

    for (int r = 0; r < 6; r++) begin
      fill_rand($urandom_range(0, 20), $urandom_range(4, 30));
      rc = model();
      measure($sformatf("rand%0d", r), r[0], 1'b0, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
